red_arbiter: RTL and testbench

RED_ARBITER -- requirements
Module: red_arbiter

---
 rtl/red_ctrl_pkg.sv | 24 ++
 rtl/RED_16b.sv | 21 ++
 rtl/red_arbiter.sv | 115 +++++++++++
 tb/tb_red_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_ctrl_pkg.sv
// Shared control types for the two-requester reduction arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package red_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ID_W   = 1;
  localparam int CNT_W  = 4;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Operand pair captured from the winning requester
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

endpackage

// File: rtl/RED_16b.sv
// Reduction datapath: sums the eight nibbles of a and b into a 7-bit signed accumulator.
// Latency: combinational.
// Backpressure: none; the caller holds the operands stable.
module RED_16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);

  logic [6:0] acc;

  // Accumulate nibbles in 7 bits, then sign-extend the accumulator to 16 bits
  always_comb begin
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + 7'(a_i[4*i +: 4]) + 7'(b_i[4*i +: 4]);
    end
    y_o = {{9{acc[6]}}, acc};
  end

endmodule

// File: rtl/red_arbiter.sv
// Round-robin arbiter sharing one RED_16b datapath between two requesters.
// Latency: EXEC_CYCLES+1 cycles from the sampling edge to the done pulse.
// Backpressure: requests are ignored while busy; a held request is re-arbitrated in IDLE.
module red_arbiter
  import red_ctrl_pkg::*;
#(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] opA0,
  input  logic [15:0] opB0,
  input  logic [15:0] opA1,
  input  logic [15:0] opB1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  req_id_t           ptr_q;   // requester favoured on a tie
  req_id_t           id_q;    // requester owning the in-flight operation
  req_id_t           win_id;
  op_t               op_q;
  logic [1:0]        gnt_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] red_y;
  logic              any_req;
  logic              last_exec;

  assign any_req   = req0 | req1;
  assign last_exec = (cnt_q == '0);

  // Winner selection: a sole requester wins, a tie goes to the pointer
  always_comb begin
    win_id = '0;
    if (req0 && req1) begin
      win_id = ptr_q;
    end else if (req1) begin
      win_id = req_id_t'(1);
    end
  end

  RED_16b u_red (
    .a_i (op_q.a),
    .b_i (op_q.b),
    .y_o (red_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: RESP always returns to IDLE so a held request waits one idle cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)   state_d = ST_EXEC;
      ST_EXEC: if (last_exec) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, EXEC down-counter, round-robin pointer, grant pulse and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ptr_q <= '0;
      id_q  <= '0;
      op_q  <= '0;
      gnt_q <= '0;
      res_q <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            id_q  <= win_id;
            op_q  <= (win_id != '0) ? op_t'{a: opA1, b: opB1} : op_t'{a: opA0, b: opB0};
            cnt_q <= CNT_LOAD;
            ptr_q <= ~win_id;
            gnt_q <= (win_id != '0) ? 2'b10 : 2'b01;
          end
        end
        ST_EXEC: begin
          if (last_exec) res_q <= red_y;
          else           cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and the owning requester id
  always_comb begin
    busy  = (state_q != ST_IDLE);
    gnt0  = gnt_q[0];
    gnt1  = gnt_q[1];
    done0 = (state_q == ST_RESP) && (id_q == '0);
    done1 = (state_q == ST_RESP) && (id_q != '0);
    res   = res_q;
  end

endmodule

// File: tb/tb_red_arbiter.sv
// Bench for red_arbiter: EXEC_CYCLES=2 instance plus an EXEC_CYCLES=1 instance.
// Latency: expected grant/done timing carried in a scoreboard queue.
// Backpressure: requests held or dropped on grant depending on the scenario.
module tb_red_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, gnt0, gnt1, done0, done1, busy;
  logic [15:0] opA0, opB0, opA1, opB1, res;
  logic        f_req0, f_req1, f_gnt0, f_gnt1, f_done0, f_done1, f_busy;
  logic [15:0] f_opA0, f_opB0, f_opA1, f_opB1, f_res;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    int          id;
    logic [15:0] res;
    int          gnt_at;
    int          lat;
    int          idle;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  red_arbiter #(.EXEC_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .opA0(opA0), .opB0(opB0), .opA1(opA1), .opB1(opB1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .busy(busy)
  );

  red_arbiter #(.EXEC_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst), .req0(f_req0), .req1(f_req1),
    .opA0(f_opA0), .opB0(f_opB0), .opA1(f_opA1), .opB1(f_opB1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
    .res(f_res), .busy(f_busy)
  );

  // Reference reduction: nibble sum of both operands, 7-bit signed, sign-extended
  function automatic logic [15:0] red_model(input logic [15:0] a, input logic [15:0] b);
    int         s;
    logic [6:0] s7;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(a[4*i +: 4]) + int'(b[4*i +: 4]);
    s7 = s[6:0];
    return {{9{s7[6]}}, s7};
  endfunction

  // Watch one instance until a done pulse (bounded); optionally drop/scramble the winner on grant
  task automatic collect(input bit fast, input bit drop_on_gnt, input bit scramble,
                         output int g_id, output int g_at, output int g_cnt,
                         output int d_id, output logic [15:0] d_res, output int d_at,
                         output int idle, output bit ovl, output bit tmo);
    logic g0, g1, dn0, dn1, bz;
    logic [15:0] r;
    g_id = -1; g_at = -1; g_cnt = 0; d_id = -1; d_res = 'x; d_at = -1;
    idle = 0; ovl = 1'b0; tmo = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (fast) begin
        g0 = f_gnt0; g1 = f_gnt1; dn0 = f_done0; dn1 = f_done1; bz = f_busy; r = f_res;
      end else begin
        g0 = gnt0; g1 = gnt1; dn0 = done0; dn1 = done1; bz = busy; r = res;
      end
      if ((g0 && g1) || (dn0 && dn1)) ovl = 1'b1;
      if (g0 || g1) g_cnt++;
      if (!bz && g_id < 0) idle++;
      if ((g0 || g1) && g_id < 0) begin
        g_id = g1 ? 1 : 0;
        g_at = k;
        if (drop_on_gnt) begin
          if (fast) begin
            if (g1) f_req1 = 1'b0; else f_req0 = 1'b0;
          end else begin
            if (g1) req1 = 1'b0; else req0 = 1'b0;
          end
        end
        if (scramble) begin
          if (fast) begin
            if (g1) begin f_opA1 = ~f_opA1; f_opB1 = ~f_opB1; end
            else    begin f_opA0 = ~f_opA0; f_opB0 = ~f_opB0; end
          end else begin
            if (g1) begin opA1 = ~opA1; opB1 = ~opB1; end
            else    begin opA0 = ~opA0; opB0 = ~opB0; end
          end
        end
      end
      if (dn0 || dn1) begin
        d_id = dn1 ? 1 : 0; d_res = r; d_at = k; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; opA0 = 0; opB0 = 0; opA1 = 0; opB1 = 0;
    f_req0 = 0; f_req1 = 0; f_opA0 = 0; f_opB0 = 0; f_opA1 = 0; f_opB1 = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {gnt0, gnt1, done0, done1, busy});
    else n_pass++;
    n_checks++;
    if (res !== 16'h0000) $display("FAIL reset_res: got %h want 0000", res);
    else n_pass++;
    n_checks++;
    if ({f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_res} !== 21'b0)
      $display("FAIL reset_fast: got %b/%h want 00000/0000",
               {f_gnt0, f_gnt1, f_done0, f_done1, f_busy}, f_res);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single();
    exp_t e; int g_id, g_at, g_cnt, d_id, d_at, idle; logic [15:0] d_res; bit ovl, tmo;
    logic [55:0] obs, want;
    repeat (2) @(negedge clk);
    opA0 = 16'h1234; opB0 = 16'h5678; req0 = 1'b1;
    exp_q.push_back('{0, 16'h0024, 1, 3, 0});
    collect(1'b0, 1'b1, 1'b1, g_id, g_at, g_cnt, d_id, d_res, d_at, idle, ovl, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (d_res !== e.res) $display("FAIL single_res: got %h want %h", d_res, e.res);
    else n_pass++;
    obs  = {8'(tmo), 8'(ovl), 8'(g_cnt), 4'(g_id), 4'(d_id), 8'(g_at), 8'(d_at - g_at + 1), 8'(idle)};
    want = {8'd0, 8'd0, 8'd1, 4'(e.id), 4'(e.id), 8'(e.gnt_at), 8'(e.lat), 8'(e.idle)};
    n_checks++;
    if (obs !== want) $display("FAIL single_timing: got %h want %h (tmo,ovl,gcnt,gid,did,gat,lat,idle)", obs, want);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({res, busy, done0, done1} !== {16'h0024, 3'b000})
      $display("FAIL single_hold: got res=%h busy=%b done=%b%b want res=0024 idle", res, busy, done0, done1);
    else n_pass++;
  endtask

  task automatic test_tie();
    exp_t e; int g_id, g_at, g_cnt, d_id, d_at, idle; logic [15:0] d_res; bit ovl, tmo;
    logic [55:0] obs, want;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    opA0 = 16'h1234; opB0 = 16'h5678; opA1 = 16'hFFFF; opB1 = 16'hFFFF;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{0, 16'h0024, 1, 3, 0});
    exp_q.push_back('{1, 16'hFFF8, 2, 3, 1});
    for (int i = 0; i < 2; i++) begin
      collect(1'b0, 1'b1, 1'b0, g_id, g_at, g_cnt, d_id, d_res, d_at, idle, ovl, tmo);
      e = exp_q.pop_front();
      n_checks++;
      if (d_res !== e.res) $display("FAIL tie_res op%0d: got %h want %h", i, d_res, e.res);
      else n_pass++;
      obs  = {8'(tmo), 8'(ovl), 8'(g_cnt), 4'(g_id), 4'(d_id), 8'(g_at), 8'(d_at - g_at + 1), 8'(idle)};
      want = {8'd0, 8'd0, 8'd1, 4'(e.id), 4'(e.id), 8'(e.gnt_at), 8'(e.lat), 8'(e.idle)};
      n_checks++;
      if (obs !== want) $display("FAIL tie_timing op%0d: got %h want %h (tmo,ovl,gcnt,gid,did,gat,lat,idle)", i, obs, want);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int g_id, g_at, g_cnt, d_id, d_at, idle; logic [15:0] d_res; bit ovl, tmo;
    logic [55:0] obs, want;
    repeat (2) @(negedge clk);
    opA0 = 16'hAAAA; opB0 = 16'h5555; opA1 = 16'h0001; opB1 = 16'h0002;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{0, red_model(16'hAAAA, 16'h5555), 1, 3, 0});
    exp_q.push_back('{1, red_model(16'h0001, 16'h0002), 2, 3, 1});
    exp_q.push_back('{0, red_model(16'hAAAA, 16'h5555), 2, 3, 1});
    exp_q.push_back('{1, red_model(16'h0001, 16'h0002), 2, 3, 1});
    for (int i = 0; i < 4; i++) begin
      collect(1'b0, 1'b0, 1'b0, g_id, g_at, g_cnt, d_id, d_res, d_at, idle, ovl, tmo);
      e = exp_q.pop_front();
      n_checks++;
      if (d_res !== e.res) $display("FAIL b2b_res op%0d: got %h want %h", i, d_res, e.res);
      else n_pass++;
      obs  = {8'(tmo), 8'(ovl), 8'(g_cnt), 4'(g_id), 4'(d_id), 8'(g_at), 8'(d_at - g_at + 1), 8'(idle)};
      want = {8'd0, 8'd0, 8'd1, 4'(e.id), 4'(e.id), 8'(e.gnt_at), 8'(e.lat), 8'(e.idle)};
      n_checks++;
      if (obs !== want) $display("FAIL b2b_timing op%0d: got %h want %h (tmo,ovl,gcnt,gid,did,gat,lat,idle)", i, obs, want);
      else n_pass++;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset_exec();
    exp_t e; int g_id, g_at, g_cnt, d_id, d_at, idle; logic [15:0] d_res; bit ovl, tmo;
    logic [55:0] obs, want;
    bit saw_done;
    repeat (2) @(negedge clk);
    opA0 = 16'h0F0F; opB0 = 16'h0F0F; req0 = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({gnt0, busy} !== 2'b11) $display("FAIL rstexec_grant: got gnt0,busy=%b want 11", {gnt0, busy});
    else n_pass++;
    req0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({res, busy, gnt0, gnt1, done0, done1} !== 21'b0)
      $display("FAIL rstexec_abort: got res=%h busy=%b gnt=%b%b done=%b%b want all 0",
               res, busy, gnt0, gnt1, done0, done1);
    else n_pass++;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || done1 || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL rstexec_no_done: got activity=%b want 0", saw_done);
    else n_pass++;
    // Pointer must favour requester 0 again after reset
    opA0 = 16'h2222; opB0 = 16'h3333; opA1 = 16'h000F; opB1 = 16'h00F0;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{0, red_model(16'h2222, 16'h3333), 1, 3, 0});
    exp_q.push_back('{1, red_model(16'h000F, 16'h00F0), 2, 3, 1});
    for (int i = 0; i < 2; i++) begin
      collect(1'b0, 1'b1, 1'b0, g_id, g_at, g_cnt, d_id, d_res, d_at, idle, ovl, tmo);
      e = exp_q.pop_front();
      n_checks++;
      if (d_res !== e.res) $display("FAIL rstexec_res op%0d: got %h want %h", i, d_res, e.res);
      else n_pass++;
      obs  = {8'(tmo), 8'(ovl), 8'(g_cnt), 4'(g_id), 4'(d_id), 8'(g_at), 8'(d_at - g_at + 1), 8'(idle)};
      want = {8'd0, 8'd0, 8'd1, 4'(e.id), 4'(e.id), 8'(e.gnt_at), 8'(e.lat), 8'(e.idle)};
      n_checks++;
      if (obs !== want) $display("FAIL rstexec_timing op%0d: got %h want %h (tmo,ovl,gcnt,gid,did,gat,lat,idle)", i, obs, want);
      else n_pass++;
    end
  endtask

  task automatic test_fast_exec();
    exp_t e; int g_id, g_at, g_cnt, d_id, d_at, idle; logic [15:0] d_res; bit ovl, tmo;
    logic [55:0] obs, want;
    repeat (2) @(negedge clk);
    f_opA1 = 16'h2864; f_opB1 = 16'h1907; f_req1 = 1'b1;
    exp_q.push_back('{1, 16'h0025, 1, 2, 0});
    collect(1'b1, 1'b1, 1'b1, g_id, g_at, g_cnt, d_id, d_res, d_at, idle, ovl, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (d_res !== e.res) $display("FAIL fast_res: got %h want %h", d_res, e.res);
    else n_pass++;
    obs  = {8'(tmo), 8'(ovl), 8'(g_cnt), 4'(g_id), 4'(d_id), 8'(g_at), 8'(d_at - g_at + 1), 8'(idle)};
    want = {8'd0, 8'd0, 8'd1, 4'(e.id), 4'(e.id), 8'(e.gnt_at), 8'(e.lat), 8'(e.idle)};
    n_checks++;
    if (obs !== want) $display("FAIL fast_timing: got %h want %h (tmo,ovl,gcnt,gid,did,gat,lat,idle)", obs, want);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({f_res, f_busy} !== {16'h0025, 1'b0}) $display("FAIL fast_hold: got res=%h busy=%b want 0025/0", f_res, f_busy);
    else n_pass++;
  endtask

  task automatic test_req_in_resp();
    exp_t e; int g_id, g_at, g_cnt, d_id, d_at, idle; logic [15:0] d_res; bit ovl, tmo;
    logic [55:0] obs, want;
    repeat (2) @(negedge clk);
    opA0 = 16'h1111; opB0 = 16'h2222; req0 = 1'b1;
    exp_q.push_back('{0, red_model(16'h1111, 16'h2222), 1, 3, 0});
    exp_q.push_back('{1, 16'hFFCD, 2, 3, 1});
    for (int i = 0; i < 2; i++) begin
      collect(1'b0, 1'b1, 1'b0, g_id, g_at, g_cnt, d_id, d_res, d_at, idle, ovl, tmo);
      // Raise req1 while the requester-0 operation is in RESP
      if (i == 0) begin
        opA1 = 16'h2DE4; opB1 = 16'hACF7; req1 = 1'b1;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (d_res !== e.res) $display("FAIL respreq_res op%0d: got %h want %h", i, d_res, e.res);
      else n_pass++;
      obs  = {8'(tmo), 8'(ovl), 8'(g_cnt), 4'(g_id), 4'(d_id), 8'(g_at), 8'(d_at - g_at + 1), 8'(idle)};
      want = {8'd0, 8'd0, 8'd1, 4'(e.id), 4'(e.id), 8'(e.gnt_at), 8'(e.lat), 8'(e.idle)};
      n_checks++;
      if (obs !== want) $display("FAIL respreq_timing op%0d: got %h want %h (tmo,ovl,gcnt,gid,did,gat,lat,idle)", i, obs, want);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_reset_exec();
    test_fast_exec();
    test_req_in_resp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
